fetch_queue: RTL

- Parametrised fetch stage that generates the PC and reads the instruction memory.
- Buffers {pc, pc+4, instr} in a DEPTH-entry FIFO, so decode stalls no longer freeze the PC.
- Sits between the PC/instruction memory and decode, and replaces the single fetch/decode pipeline register.
- Adds decode backpressure (valid/ready), memory wait states, and a redirect that flushes all buffered entries and loads the target.

---
 rtl/fetch_queue.sv | 109 ++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - PC generator and instruction fetch FIFO feeding decode
// Entries carry {pc, pc+4, instr}; outputs fall back to constants whenever the queue is empty.
module fetch_queue #(
    parameter int               XLEN     = 32,
    parameter int               ILEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter logic [ILEN-1:0]  NOP      = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      redirect_valid,
    input  logic [XLEN-1:0]           redirect_target,
    output logic [XLEN-1:0]           imem_addr,
    input  logic [ILEN-1:0]           imem_rdata,
    input  logic                      imem_ready,
    output logic                      dec_valid,
    input  logic                      dec_ready,
    output logic [ILEN-1:0]           dec_instr,
    output logic [XLEN-1:0]           dec_pc,
    output logic [XLEN-1:0]           dec_pcplus4,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [XLEN-1:0] pc_mem_q      [DEPTH];
    logic [XLEN-1:0] pcplus4_mem_q [DEPTH];
    logic [ILEN-1:0] instr_mem_q   [DEPTH];

    logic            full;
    logic            deq;
    logic            enq;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] target_aligned;
    logic            target_lsb_unused;

    assign target_lsb_unused = ^redirect_target[1:0];
    assign target_aligned    = {redirect_target[XLEN-1:2], 2'b00};
    assign pc_plus4          = pc_q + XLEN'(4);

    assign full      = (count_q == CW'(DEPTH));
    assign dec_valid = (count_q != '0);
    assign deq       = dec_valid & dec_ready;
    // A full queue still accepts a fetch when decode drains the head in the same cycle.
    assign enq       = imem_ready & ~redirect_valid & (~full | deq);

    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            pc_d     = target_aligned;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                pc_d     = pc_plus4;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (enq && !deq) begin
                count_d = count_q + CW'(1);
            end else if (deq && !enq) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is left unreset; stale contents are never presented because outputs are gated by count.
    always_ff @(posedge clk) begin
        if (!rst && enq) begin
            pc_mem_q[wr_ptr_q]      <= pc_q;
            pcplus4_mem_q[wr_ptr_q] <= pc_plus4;
            instr_mem_q[wr_ptr_q]   <= imem_rdata;
        end
    end

    assign imem_addr   = pc_q;
    assign occupancy   = count_q;
    assign dec_instr   = dec_valid ? instr_mem_q[rd_ptr_q]   : NOP;
    assign dec_pc      = dec_valid ? pc_mem_q[rd_ptr_q]      : '0;
    assign dec_pcplus4 = dec_valid ? pcplus4_mem_q[rd_ptr_q] : '0;

endmodule
